rr_dispatcher: RTL

RR_DISPATCHER -- requirements
Module: rr_dispatcher

---
 rtl/rr_dispatch_pkg.sv | 15 +
 rtl/rr_dispatcher_if.sv | 30 +++
 rtl/rr_select.sv | 29 ++
 rtl/rr_dispatcher.sv | 100 ++++++++++
 4 files changed

// File: rtl/rr_dispatch_pkg.sv
// Shared types and helpers for the round-robin packet dispatcher.
package rr_dispatch_pkg;

    // Dispatcher FSM: IDLE picks a new target per accepted beat, LOCKED holds it.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Increment an output index, wrapping from n-1 back to 0.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_dispatcher_if.sv
// Stream-in / fan-out bus of the round-robin dispatcher.
interface rr_dispatcher_if #(
    parameter int NUM_OUTS     = 5,
    parameter int DATA_WIDTH   = 8,
    parameter int LOG_NUM_OUTS = $clog2(NUM_OUTS)
);
    logic [DATA_WIDTH-1:0]   s_data;
    logic                    s_valid;
    logic                    s_last;
    logic                    s_ready;
    logic [NUM_OUTS-1:0]     out_en;
    logic [DATA_WIDTH-1:0]   m_data;
    logic                    m_last;
    logic [NUM_OUTS-1:0]     m_valid;
    logic [NUM_OUTS-1:0]     m_ready;
    logic [LOG_NUM_OUTS-1:0] sel_index;
    logic                    busy;

    // Dispatcher side.
    modport slave (
        input  s_data, s_valid, s_last, out_en, m_ready,
        output s_ready, m_data, m_last, m_valid, sel_index, busy
    );

    // Source / sink side.
    modport master (
        output s_data, s_valid, s_last, out_en, m_ready,
        input  s_ready, m_data, m_last, m_valid, sel_index, busy
    );
endinterface

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set mask bit at or above ptr, wrapping.
module rr_select #(
    parameter int N  = 5,
    parameter int LW = $clog2(N)
) (
    input  logic [N-1:0]  mask_i,
    input  logic [LW-1:0] ptr_i,
    output logic [LW-1:0] idx_o,
    output logic          found_o
);
    // Rotate the mask so that bit 0 corresponds to the pointer position.
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;

    assign dbl = {mask_i, mask_i} >> ptr_i;
    assign rot = dbl[N-1:0];

    // Lowest set bit of the rotated mask, mapped back to an absolute index.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found_o && rot[j]) begin
                found_o = 1'b1;
                idx_o   = LW'((int'(ptr_i) + j) % N);
            end
        end
    end
endmodule

// File: rtl/rr_dispatcher.sv
// Round-robin dispatcher: one input stream fanned out to NUM_OUTS outputs
// through a single output register, with optional whole-packet target lock.
module rr_dispatcher
    import rr_dispatch_pkg::*;
#(
    parameter int NUM_OUTS     = 5,
    parameter int DATA_WIDTH   = 8,
    parameter int LOCK_ENABLE  = 1,
    parameter int LOG_NUM_OUTS = $clog2(NUM_OUTS)
) (
    input logic          clk,
    input logic          reset_n,
    rr_dispatcher_if.slave bus
);
    logic                    full_q,  full_d;
    logic [DATA_WIDTH-1:0]   data_q,  data_d;
    logic                    last_q,  last_d;
    logic [LOG_NUM_OUTS-1:0] idx_q,   idx_d;
    logic [LOG_NUM_OUTS-1:0] ptr_q,   ptr_d;
    state_e                  state_q, state_d;

    logic [LOG_NUM_OUTS-1:0] sel_idx;
    logic                    sel_found;
    logic [LOG_NUM_OUTS-1:0] target;
    logic                    room;
    logic                    drain;
    logic                    accept;

    rr_select #(
        .N  (NUM_OUTS),
        .LW (LOG_NUM_OUTS)
    ) u_select (
        .mask_i  (bus.out_en),
        .ptr_i   (ptr_q),
        .idx_o   (sel_idx),
        .found_o (sel_found)
    );

    // A locked packet keeps its target; otherwise the picker chooses.
    assign target = (state_q == LOCKED) ? idx_q : sel_idx;
    assign drain  = full_q & bus.m_ready[idx_q];
    assign room   = ~full_q | bus.m_ready[idx_q];

    // Ready never looks at s_valid, only at register space and target availability.
    assign bus.s_ready = room & ((state_q == LOCKED) | sel_found);
    assign accept      = bus.s_valid & bus.s_ready;

    assign bus.m_valid   = full_q ? (NUM_OUTS'(1) << idx_q) : '0;
    assign bus.m_data    = data_q;
    assign bus.m_last    = last_q;
    assign bus.sel_index = idx_q;
    assign bus.busy      = (state_q == LOCKED);

    // Next-state: load on accept (covers simultaneous drain), else drain empties.
    always_comb begin
        full_d  = full_q;
        data_d  = data_q;
        last_d  = last_q;
        idx_d   = idx_q;
        state_d = state_q;
        ptr_d   = ptr_q;
        if (accept) begin
            full_d = 1'b1;
            data_d = bus.s_data;
            last_d = bus.s_last;
            idx_d  = target;
            if (LOCK_ENABLE != 0) begin
                if (state_q == IDLE && !bus.s_last) begin
                    state_d = LOCKED;
                end else if (state_q == LOCKED && bus.s_last) begin
                    state_d = IDLE;
                end
            end
            if (LOCK_ENABLE == 0 || bus.s_last) begin
                ptr_d = LOG_NUM_OUTS'(wrap_inc(int'(target), NUM_OUTS));
            end
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    // State registers; reset drops any in-flight beat and lock immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_q  <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= '0;
            state_q <= IDLE;
        end else begin
            full_q  <= full_d;
            data_q  <= data_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            state_q <= state_d;
        end
    end
endmodule
